// File: rtl/mod_counter_pkg.sv
// counter_pkg: mode codes and one-shot state encoding shared by the counter and its users.
package counter_pkg;
    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } st_e;
endpackage

// File: rtl/mod_counter_if.sv
// mod_counter_if: control, bound and status signals of the programmable counter.
interface mod_counter_if #(parameter int BITS = 8);
    logic            cnt;
    logic            dir;
    logic            load;
    logic [BITS-1:0] din;
    logic [BITS-1:0] max;
    logic [1:0]      mode;
    logic            tc;
    logic            wrap;
    logic            busy;
    logic [BITS-1:0] val;
    modport master (output cnt, dir, load, din, max, mode, input tc, wrap, busy, val);
    modport slave  (input cnt, dir, load, din, max, mode, output tc, wrap, busy, val);
endinterface

// File: rtl/mod_counter.sv
// mod_counter: up/down counter with clamped load, programmable bound and wrap/saturate/one-shot modes.
module mod_counter
    import counter_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    mod_counter_if.slave bus
);
    logic [BITS-1:0] r_val;
    logic            r_wrap;
    st_e             r_st;
    st_e             w_st_nxt;
    logic            w_os;
    logic            w_sat;
    logic            w_term;
    logic            w_step;
    logic            w_arr;
    logic            w_busy;
    logic [BITS-1:0] w_clamp;
    logic [BITS-1:0] w_adj;
    logic [BITS-1:0] w_val_nxt;
    logic            w_wrap_nxt;
    // Mode 11 falls through to wrap behaviour since neither flag is set.
    always_comb begin
        w_os       = bus.mode == MODE_ONESHOT;
        w_sat      = bus.mode == MODE_SAT;
        w_clamp    = (bus.din > bus.max) ? bus.max : bus.din;
        w_step     = bus.cnt & (~w_os | (r_st == ST_RUN));
        w_term     = bus.dir ? (r_val == '0) : (r_val >= bus.max);
        w_adj      = bus.dir ? r_val - BITS'(1) : r_val + BITS'(1);
        w_arr      = bus.dir ? (w_adj == '0) : (w_adj == bus.max);
        w_val_nxt  = bus.load ? w_clamp :
                     !w_step ? r_val :
                     !w_term ? w_adj :
                     (w_os | w_sat) ? r_val :
                     bus.dir ? bus.max : '0;
        w_wrap_nxt = ~bus.load & w_step & (w_term ? ~w_sat : (w_sat & w_arr));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_val  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_val  <= w_val_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) r_st <= ST_IDLE;
        else     r_st <= w_st_nxt;
    end
    always_comb begin
        w_st_nxt = !w_os ? ST_IDLE :
                   bus.load ? ST_RUN :
                   (r_st == ST_RUN && bus.cnt && w_term) ? ST_DONE : r_st;
    end
    always_comb begin
        w_busy = r_st == ST_RUN;
    end
    assign bus.tc   = w_term;
    assign bus.wrap = r_wrap;
    assign bus.busy = w_busy;
    assign bus.val  = r_val;
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed spec scenarios plus random traffic against a rule-level reference model.
module tb_mod_counter;
    localparam int BITS = 4;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    int   m_val = 0;
    bit   m_wrap = 0;
    bit   m_run = 0;
    mod_counter_if #(.BITS(BITS)) bus ();
    mod_counter #(.BITS(BITS)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    // Reference: applies the counting rules directly to integer state; idle and done are
    // indistinguishable from outside, so only "running" is tracked for one-shot.
    task automatic model_edge();
        int  v  = m_val;
        int  mx = int'(bus.max);
        bit  os = bus.mode == 2'b10;
        bit  sat = bus.mode == 2'b01;
        bit  term = bus.dir ? (v == 0) : (v >= mx);
        if (rst) begin
            m_val = 0; m_wrap = 0; m_run = 0;
            return;
        end
        m_wrap = 0;
        if (!os) m_run = 0;
        if (bus.load) begin
            m_val = (int'(bus.din) > mx) ? mx : int'(bus.din);
            if (os) m_run = 1;
        end else if (bus.cnt && (!os || m_run)) begin
            if (!term) begin
                m_val = bus.dir ? v - 1 : v + 1;
                if (sat && m_val == (bus.dir ? 0 : mx)) m_wrap = 1;
            end else if (os) begin
                m_run = 0; m_wrap = 1;
            end else if (!sat) begin
                m_val = bus.dir ? mx : 0; m_wrap = 1;
            end
        end
    endtask
    task automatic cyc();
        #1;
        if (!rst) check("tc", int'(bus.tc), int'(bus.dir ? (m_val == 0) : (m_val >= int'(bus.max))));
        @(posedge clk);
        model_edge();
        #1;
        check("val", int'(bus.val), m_val);
        check("wrap", int'(bus.wrap), int'(m_wrap));
        check("busy", int'(bus.busy), int'(m_run));
    endtask
    initial begin
        rst = 1; bus.cnt = 1; bus.dir = 1; bus.load = 0; bus.din = 0; bus.max = 9; bus.mode = 2'b00;
        repeat (2) cyc();
        check("rst_val", int'(bus.val), 0);
        rst = 0; bus.cnt = 0;
        cyc();
        bus.dir = 0;
        cyc();
        bus.cnt = 1;
        repeat (12) cyc();
        bus.max = 5; bus.load = 1; bus.din = 2; bus.dir = 1;
        cyc();
        bus.load = 0;
        repeat (5) cyc();
        bus.load = 1; bus.din = 12;
        cyc();
        check("clamp", int'(bus.val), 5);
        bus.mode = 2'b01; bus.max = 3; bus.din = 0; bus.dir = 0;
        cyc();
        bus.load = 0;
        repeat (6) cyc();
        bus.mode = 2'b10; bus.max = 4;
        repeat (2) cyc();
        bus.load = 1; bus.din = 0;
        cyc();
        bus.load = 0;
        repeat (7) cyc();
        check("os_val", int'(bus.val), 4);
        bus.load = 1; bus.din = 1;
        cyc();
        bus.load = 0;
        repeat (2) cyc();
        bus.mode = 2'b00; bus.load = 1; bus.din = 3;
        cyc();
        rst = 1; bus.din = 7;
        cyc();
        rst = 0; bus.mode = 2'b10; bus.din = 0;
        cyc();
        bus.load = 0; bus.mode = 2'b00;
        repeat (3) cyc();
        bus.max = 0;
        repeat (3) cyc();
        bus.dir = 1; bus.mode = 2'b11;
        repeat (3) cyc();
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 63) == 0);
            bus.load = ($urandom_range(0, 7) == 0);
            bus.cnt  = ($urandom_range(0, 3) != 0);
            bus.din  = BITS'($urandom);
            if ($urandom_range(0, 7) == 0) bus.dir = ~bus.dir;
            if ($urandom_range(0, 31) == 0) bus.max = BITS'($urandom);
            if ($urandom_range(0, 47) == 0) bus.mode = 2'($urandom);
            cyc();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
